dbuf_pingpong_ctrl: RTL and testbench

Fill/drain controller for the 4096×40 ping-pong double buffer. Accepts a valid/ready stream of 40-bit words, writes each frame of FRAME_WORDS words into one bank while the other bank is read out sequentially to a downstream valid/ready consumer, and swaps bank roles on frame boundaries. It sits directly upstream of the double buffer, driving its write and read ports and bank selects, and it re-streams the buffer's registered read data.

---
 rtl/dbuf_pingpong_ctrl.sv | 118 +++++++++++
 tb/tb_dbuf_pingpong_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbuf_pingpong_ctrl.sv
// Fill/drain controller for a two-bank ping-pong buffer: one bank is written from the
// input stream while the other is read out through a 2-entry skid FIFO.
module dbuf_pingpong_ctrl #(
  parameter int AWIDTH      = 12,
  parameter int NUM_WORDS   = 4096,
  parameter int DWIDTH      = 40,
  parameter int FRAME_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              wr_bank,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        bank_full
);

  localparam int FW = (FRAME_WORDS > NUM_WORDS) ? NUM_WORDS : FRAME_WORDS;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(FW - 1);
  localparam logic [AWIDTH:0]   FRAME_LEN = (AWIDTH+1)'(FW);

  logic              fb_q, fb_d, db_q, db_d;
  logic [AWIDTH-1:0] wa_q, wa_d, cnt_q, cnt_d;
  logic [AWIDTH:0]   ra_q, ra_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        occ_q, occ_d;
  logic              wp_q, wp_d, rp_q, rp_d;
  logic              infl_q, infl_d;
  logic [DWIDTH-1:0] skid_mem [2];
  logic              pop, push, fill_done, last_pop;
  logic [2:0]        credit;

  always_comb begin
    in_ready  = ~full_q[fb_q];
    wr_en     = in_valid & ~full_q[fb_q] & ~reset;
    wr_bank   = fb_q;
    wr_addr   = wa_q;
    wr_data   = in_data;
    out_valid = (occ_q != 2'd0);
    out_data  = out_valid ? skid_mem[rp_q] : '0;
    bank_full = full_q;
    pop       = out_valid & out_ready;
    push      = infl_q;
    // Slots already committed (held + in flight) minus the one leaving this cycle.
    credit    = 3'(occ_q) + 3'(infl_q) - 3'(pop);
    rd_en     = full_q[db_q] & (ra_q < FRAME_LEN) & (credit < 3'd2);
    rd_bank   = db_q;
    rd_addr   = ra_q[AWIDTH-1:0];
    fill_done = wr_en & (wa_q == LAST_ADDR);
    last_pop  = pop & (cnt_q == LAST_ADDR);

    fb_d   = fb_q;
    wa_d   = wa_q;
    db_d   = db_q;
    ra_d   = rd_en ? ra_q + (AWIDTH+1)'(1) : ra_q;
    cnt_d  = pop ? cnt_q + AWIDTH'(1) : cnt_q;
    full_d = full_q;
    if (wr_en) begin
      wa_d = fill_done ? '0 : wa_q + AWIDTH'(1);
      fb_d = fill_done ? ~fb_q : fb_q;
    end
    // Set and clear always hit different banks, so applying both is safe.
    if (last_pop) begin
      full_d[db_q] = 1'b0;
      db_d         = ~db_q;
      ra_d         = '0;
      cnt_d        = '0;
    end
    if (fill_done) full_d[fb_q] = 1'b1;
    infl_d = rd_en;
    occ_d  = occ_q + 2'(push) - 2'(pop);
    wp_d   = wp_q ^ push;
    rp_d   = rp_q ^ pop;
  end

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_q   <= 1'b0;
      db_q   <= 1'b0;
      wa_q   <= '0;
      ra_q   <= '0;
      cnt_q  <= '0;
      full_q <= 2'b00;
      occ_q  <= 2'd0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      infl_q <= 1'b0;
    end else begin
      fb_q   <= fb_d;
      db_q   <= db_d;
      wa_q   <= wa_d;
      ra_q   <= ra_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      occ_q  <= occ_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      infl_q <= infl_d;
    end
  end

  // Skid FIFO payload; validity is carried by occ_q alone
  always_ff @(posedge clk) begin
    if (push) skid_mem[wp_q] <= rd_data;
  end

endmodule

// File: tb/tb_dbuf_pingpong_ctrl.sv
// Scoreboard bench for dbuf_pingpong_ctrl: three instances (frame sizes 4096, 16, 2)
// each backed by a behavioural two-bank memory with one-cycle read latency.
`timescale 1ns/1ps
module tb_dbuf_pingpong_ctrl;
  localparam int AW = 12;
  localparam int DW = 40;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic [NI-1:0]         rst, in_valid, in_ready, wr_bank, wr_en, rd_bank, rd_en;
  logic [NI-1:0]         out_valid, out_ready;
  logic [NI-1:0][DW-1:0] in_data, wr_data, rd_data, out_data;
  logic [NI-1:0][AW-1:0] wr_addr, rd_addr;
  logic [NI-1:0][1:0]    bank_full;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int sent = 0;
  int steps = 0;
  logic hs;
  logic [DW-1:0] sbq [NI][$];
  int rd_cnt [NI];
  int pop_cnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int FW = (g == 0) ? 4096 : ((g == 1) ? 16 : 2);
    logic [DW-1:0] mem [2][1<<AW];
    logic [DW-1:0] rd_q;

    dbuf_pingpong_ctrl #(
      .AWIDTH(AW), .NUM_WORDS(1 << AW), .DWIDTH(DW), .FRAME_WORDS(FW)
    ) u_dut (
      .clk(clk), .reset(rst[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .wr_bank(wr_bank[g]), .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .rd_bank(rd_bank[g]), .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .bank_full(bank_full[g])
    );

    always @(posedge clk) begin
      if (wr_en[g]) mem[wr_bank[g]][wr_addr[g]] <= wr_data[g];
      if (rd_en[g]) rd_q <= mem[rd_bank[g]][rd_addr[g]];
    end
    assign rd_data[g] = rd_q;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: push accepted words, pop and compare on every output handshake
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst[g]) begin
        sbq[g].delete();
        rd_cnt[g]  <= 0;
        pop_cnt[g] <= 0;
      end else begin
        if (in_valid[g] && in_ready[g]) sbq[g].push_back(in_data[g]);
        if (rd_en[g]) rd_cnt[g] <= rd_cnt[g] + 1;
        if (out_valid[g] && out_ready[g]) begin
          pop_cnt[g] <= pop_cnt[g] + 1;
          if (sbq[g].size() == 0) chk("sb_extra_word", 64'(1), 64'(0));
          else chk("sb_data", 64'(out_data[g]), 64'(sbq[g].pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int g);
    rst[g] = 1'b1;
    in_valid[g] = 1'b0;
    tick();
    rst[g] = 1'b0;
  endtask

  task automatic send(input int g, input logic [DW-1:0] d);
    int budget;
    budget = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    while (!in_ready[g] && budget < 20000) begin
      tick();
      budget++;
      stall_cnt++;
    end
    if (!in_ready[g]) chk("send_timeout", 64'(0), 64'(1));
    tick();
  endtask

  task automatic wait_drain(input int g, input string tag);
    int n;
    n = 0;
    while ((bank_full[g] != 2'b00 || sbq[g].size() != 0 || out_valid[g]) && n < 30000) begin
      tick();
      n++;
    end
    chk({tag, "_full"}, 64'(bank_full[g]), 64'(0));
    chk({tag, "_left"}, 64'(sbq[g].size()), 64'(0));
  endtask

  initial begin
    rst = '1; in_valid = '0; out_ready = '1; in_data = '0;
    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready[0]), 64'(1));
    chk("rst_out_valid", 64'(out_valid[0]), 64'(0));
    chk("rst_rd_en", 64'(rd_en[0]), 64'(0));
    chk("rst_banks", 64'({wr_bank[0], rd_bank[0]}), 64'(0));
    chk("rst_addrs", 64'({wr_addr[0], rd_addr[0]}), 64'(0));
    chk("rst_bank_full", 64'(bank_full[0]), 64'(0));
    chk("rst_out_data", 64'(out_data[0]), 64'(0));
    in_valid[0] = 1'b1;
    #1 chk("rst_wr_en", 64'(wr_en[0]), 64'(0));
    in_valid[0] = 1'b0;
    rst = '0;

    // Single frame, drain latency
    for (int i = 0; i < 4096; i++) send(0, DW'(i));
    in_valid[0] = 1'b0;
    chk("t1_bank_full", 64'(bank_full[0]), 64'(2'b01));
    chk("t1_wr_bank", 64'(wr_bank[0]), 64'(1));
    chk("t1_rd_en_start", 64'(rd_en[0]), 64'(1));
    chk("t1_ov_e0", 64'(out_valid[0]), 64'(0));
    tick();
    chk("t1_ov_e1", 64'(out_valid[0]), 64'(0));
    tick();
    chk("t1_ov_e2", 64'(out_valid[0]), 64'(1));
    chk("t1_first_word", 64'(out_data[0]), 64'(0));
    wait_drain(0, "t1");
    chk("t1_pops", 64'(pop_cnt[0]), 64'(4096));

    // Three back-to-back frames
    do_reset(0);
    stall_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_wr_bank", 64'(wr_bank[0]), 64'(k % 2));
      for (int i = 0; i < 4096; i++) send(0, DW'(k * 4096 + i));
      if (k == 1) chk("t2_no_stall", 64'(stall_cnt), 64'(0));
    end
    in_valid[0] = 1'b0;
    wait_drain(0, "t2");
    chk("t2_pops", 64'(pop_cnt[0]), 64'(3 * 4096));

    // Both banks full under backpressure
    do_reset(0);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 8192; i++) send(0, DW'(40'h55_0000_0000 | 40'(i)));
    in_valid[0] = 1'b0;
    chk("t3_bank_full", 64'(bank_full[0]), 64'(2'b11));
    chk("t3_in_ready", 64'(in_ready[0]), 64'(0));
    repeat (4) tick();
    chk("t3_out_valid", 64'(out_valid[0]), 64'(1));
    chk("t3_head", 64'(out_data[0]), 64'(40'h55_0000_0000));
    chk("t3_reads", 64'(rd_cnt[0]), 64'(2));
    chk("t3_in_ready_hold", 64'(in_ready[0]), 64'(0));
    out_ready[0] = 1'b1;
    #1 chk("t3_resume", 64'(rd_en[0]), 64'(1));
    wait_drain(0, "t3");
    chk("t3_pops", 64'(pop_cnt[0]), 64'(8192));

    // Reset mid-frame while the other bank is partway drained
    do_reset(0);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4096; i++) send(0, DW'(40'hA0_0000_0000 | 40'(i)));
    in_valid[0] = 1'b0;
    repeat (3) tick();
    out_ready[0] = 1'b1;
    repeat (50) tick();
    out_ready[0] = 1'b0;
    chk("t5_pops", 64'(pop_cnt[0]), 64'(50));
    for (int i = 0; i < 100; i++) send(0, DW'(40'hA1_0000_0000 | 40'(i)));
    in_valid[0] = 1'b0;
    chk("t5_pre_wr_addr", 64'(wr_addr[0]), 64'(100));
    chk("t5_pre_full", 64'(bank_full[0]), 64'(2'b01));
    do_reset(0);
    chk("t5_out_valid", 64'(out_valid[0]), 64'(0));
    chk("t5_bank_full", 64'(bank_full[0]), 64'(0));
    chk("t5_in_ready", 64'(in_ready[0]), 64'(1));
    chk("t5_wr_addr", 64'(wr_addr[0]), 64'(0));
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4096; i++) send(0, DW'(40'hB0_0000_0000 | 40'(i)));
    in_valid[0] = 1'b0;
    wait_drain(0, "t5");
    chk("t5_fresh_pops", 64'(pop_cnt[0]), 64'(4096));

    // Random handshakes, 16-word frames
    in_valid[1] = 1'b0;
    while (sent < 160 && steps < 5000) begin
      if (!in_valid[1] && $urandom_range(0, 1) == 1) begin
        in_valid[1] = 1'b1;
        in_data[1]  = DW'({$urandom(), $urandom()});
      end
      out_ready[1] = 1'($urandom_range(0, 1));
      #1 hs = in_valid[1] & in_ready[1];
      tick();
      if (hs) begin
        sent++;
        in_valid[1] = 1'b0;
      end
      steps++;
    end
    in_valid[1] = 1'b0;
    chk("t4_sent", 64'(sent), 64'(160));
    steps = 0;
    while ((sbq[1].size() != 0 || bank_full[1] != 2'b00) && steps < 5000) begin
      out_ready[1] = 1'($urandom_range(0, 1));
      tick();
      steps++;
    end
    out_ready[1] = 1'b1;
    wait_drain(1, "t4");
    chk("t4_pops", 64'(pop_cnt[1]), 64'(160));

    // Two-word frames: set on bank 1 coincides with clear on bank 0
    send(2, DW'(40'hC0));
    send(2, DW'(40'hC1));
    in_valid[2] = 1'b0;
    chk("t6_full_a", 64'(bank_full[2]), 64'(2'b01));
    tick();
    tick();
    send(2, DW'(40'hC2));
    in_valid[2] = 1'b1;
    in_data[2]  = DW'(40'hC3);
    #1;
    chk("t6_pre_full", 64'(bank_full[2]), 64'(2'b01));
    chk("t6_pre_head", 64'(out_data[2]), 64'(40'hC1));
    chk("t6_pre_ready", 64'(in_ready[2]), 64'(1));
    tick();
    in_valid[2] = 1'b0;
    chk("t6_swap", 64'(bank_full[2]), 64'(2'b10));
    chk("t6_rd_bank", 64'(rd_bank[2]), 64'(1));
    wait_drain(2, "t6");
    chk("t6_pops", 64'(pop_cnt[2]), 64'(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
